// File: rtl/enemy_ai.sv
// Opponent behaviour controller: health, lane position, move pacing and a
// telegraphed wind-up/strike attack, with counter-punch damage and a terminal DEAD state.
module enemy_ai #(
    parameter int NUM_POS            = 3,
    parameter int POS_W              = 2,
    parameter int HEALTH_W           = 4,
    parameter int MAX_HEALTH         = 10,
    parameter int AGGRO_THRESH       = 6,
    parameter int CALM_DIV           = 50_000_000,
    parameter int AGGRO_DIV          = 25_000_000,
    parameter int CALM_ATTACK_EVERY  = 4,
    parameter int AGGRO_ATTACK_EVERY = 2,
    parameter int WINDUP_TICKS       = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                go,
    input  logic                hit,
    output logic [POS_W-1:0]    x_pos,
    output logic [HEALTH_W-1:0] health,
    output logic                aggressive,
    output logic                windup,
    output logic                attack,
    output logic                dead
);

    typedef enum logic [1:0] {MOVE, WINDUP, STRIKE, DEAD} state_t;

    localparam int MAX_DIV   = (CALM_DIV > AGGRO_DIV) ? CALM_DIV : AGGRO_DIV;
    localparam int TW        = $clog2(MAX_DIV);
    localparam int MAX_EVERY = (CALM_ATTACK_EVERY > AGGRO_ATTACK_EVERY) ?
                               CALM_ATTACK_EVERY : AGGRO_ATTACK_EVERY;
    localparam int MW        = $clog2(MAX_EVERY + 1);
    localparam int WW        = $clog2(WINDUP_TICKS + 1);

    state_t                state, state_n;
    logic [TW-1:0]         tick_cnt, tick_cnt_n, tick_last;
    logic [MW-1:0]         move_cnt, move_cnt_n;
    logic [WW-1:0]         wind_cnt, wind_cnt_n;
    logic [HEALTH_W-1:0]   health_n;
    logic [POS_W-1:0]      x_step, x_n;
    logic                  tick, hit_ok, kill, aggr_n, step;
    logic                  windup_n, attack_n, dead_n;
    int                    health_left;
    int                    attack_every;

    // Datapath: divider, damage/saturation, aggression and wrapped lane step.
    always_comb begin
        tick_last    = aggressive ? TW'(AGGRO_DIV - 1) : TW'(CALM_DIV - 1);
        tick         = (tick_cnt == tick_last);
        attack_every = aggressive ? AGGRO_ATTACK_EVERY : CALM_ATTACK_EVERY;
        hit_ok       = hit && (state != DEAD);
        health_left  = int'(health) - ((state == WINDUP) ? 2 : 1);
        health_n     = health;
        kill         = 1'b0;
        if (hit_ok) begin
            if (health_left <= 0) begin
                health_n = '0;
                kill     = 1'b1;
            end else begin
                health_n = HEALTH_W'(health_left);
            end
        end
        aggr_n = aggressive | (hit_ok && (int'(health_n) < AGGRO_THRESH));
        if ((aggr_n && !aggressive) || tick)
            tick_cnt_n = '0;
        else
            tick_cnt_n = tick_cnt + 1'b1;
        if (go)
            x_step = (x_pos == POS_W'(NUM_POS)) ? POS_W'(1) : x_pos + 1'b1;
        else
            x_step = (x_pos == POS_W'(1)) ? POS_W'(NUM_POS) : x_pos - 1'b1;
    end

    // Next state; a killing hit overrides every other transition.
    always_comb begin
        state_n    = state;
        move_cnt_n = move_cnt;
        wind_cnt_n = wind_cnt;
        step       = 1'b0;
        case (state)
            MOVE: begin
                if (tick) begin
                    if (int'(move_cnt) + 1 >= attack_every) begin
                        state_n    = WINDUP;
                        move_cnt_n = '0;
                        wind_cnt_n = '0;
                    end else begin
                        move_cnt_n = move_cnt + 1'b1;
                        step       = 1'b1;
                    end
                end
            end
            WINDUP: begin
                if (hit_ok) begin
                    state_n    = MOVE;
                    move_cnt_n = '0;
                end else if (tick) begin
                    if (int'(wind_cnt) + 1 >= WINDUP_TICKS)
                        state_n = STRIKE;
                    else
                        wind_cnt_n = wind_cnt + 1'b1;
                end
            end
            STRIKE: begin
                state_n    = MOVE;
                move_cnt_n = '0;
            end
            DEAD: begin
            end
        endcase
        if (kill)
            state_n = DEAD;
    end

    // Registered outputs are derived from the upcoming state.
    always_comb begin
        windup_n = (state_n == WINDUP);
        attack_n = (state_n == STRIKE);
        dead_n   = (state_n == DEAD);
        if (dead_n)
            x_n = '0;
        else if (step)
            x_n = x_step;
        else
            x_n = x_pos;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= MOVE;
            tick_cnt   <= '0;
            move_cnt   <= '0;
            wind_cnt   <= '0;
            x_pos      <= POS_W'(1);
            health     <= HEALTH_W'(MAX_HEALTH);
            aggressive <= 1'b0;
            windup     <= 1'b0;
            attack     <= 1'b0;
            dead       <= 1'b0;
        end else begin
            state      <= state_n;
            tick_cnt   <= tick_cnt_n;
            move_cnt   <= move_cnt_n;
            wind_cnt   <= wind_cnt_n;
            x_pos      <= x_n;
            health     <= health_n;
            aggressive <= aggr_n;
            windup     <= windup_n;
            attack     <= attack_n;
            dead       <= dead_n;
        end
    end

endmodule

// File: tb/tb_enemy_ai.sv
// Randomized bench for enemy_ai against a cycle-level behavioural model of the
// opponent's rules, with hit policies aimed at wind-up, strike and death corners.
module tb_enemy_ai;

    localparam int NUM_POS      = 3;
    localparam int POS_W        = 2;
    localparam int HEALTH_W     = 4;
    localparam int MAX_HEALTH   = 10;
    localparam int AGGRO_THRESH = 6;
    localparam int CALM_DIV     = 4;
    localparam int AGGRO_DIV    = 2;
    localparam int CALM_EVERY   = 4;
    localparam int AGGRO_EVERY  = 2;
    localparam int WINDUP_TICKS = 2;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                go    = 1'b0;
    logic                hit   = 1'b0;
    logic [POS_W-1:0]    x_pos;
    logic [HEALTH_W-1:0] health;
    logic                aggressive, windup, attack, dead;

    enemy_ai #(
        .NUM_POS(NUM_POS), .POS_W(POS_W), .HEALTH_W(HEALTH_W),
        .MAX_HEALTH(MAX_HEALTH), .AGGRO_THRESH(AGGRO_THRESH),
        .CALM_DIV(CALM_DIV), .AGGRO_DIV(AGGRO_DIV),
        .CALM_ATTACK_EVERY(CALM_EVERY), .AGGRO_ATTACK_EVERY(AGGRO_EVERY),
        .WINDUP_TICKS(WINDUP_TICKS)
    ) dut (
        .clock(clock), .reset(reset), .go(go), .hit(hit),
        .x_pos(x_pos), .health(health), .aggressive(aggressive),
        .windup(windup), .attack(attack), .dead(dead)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: lane, health, cycles since last tick, moves/wind-up ticks so far, phase flags.
    int m_x, m_h, m_since, m_moves, m_wt;
    bit m_aggr, m_windup, m_strike, m_dead;

    task automatic model_reset();
        m_x = 1; m_h = MAX_HEALTH; m_since = 0; m_moves = 0; m_wt = 0;
        m_aggr = 0; m_windup = 0; m_strike = 0; m_dead = 0;
    endtask

    function automatic bit model_tick_now();
        return m_since == ((m_aggr ? AGGRO_DIV : CALM_DIV) - 1);
    endfunction

    task automatic model_step(input bit g, input bit h);
        bit tick_now;
        int every, new_h;
        bit new_aggr;
        if (m_dead) return;
        tick_now = model_tick_now();
        every    = m_aggr ? AGGRO_EVERY : CALM_EVERY;
        new_h    = m_h - (m_windup ? 2 : 1);
        if (new_h < 0) new_h = 0;
        new_aggr = m_aggr || (h && new_h < AGGRO_THRESH);
        if (new_aggr && !m_aggr) m_since = 0;
        else m_since = tick_now ? 0 : m_since + 1;
        m_aggr = new_aggr;
        if (h) m_h = new_h;
        if (h && m_h == 0) begin
            m_dead = 1; m_windup = 0; m_strike = 0;
            return;
        end
        if (m_strike) begin
            m_strike = 0;
            m_moves  = 0;
        end else if (m_windup) begin
            if (h) begin
                m_windup = 0;
                m_moves  = 0;
            end else if (tick_now) begin
                m_wt++;
                if (m_wt >= WINDUP_TICKS) begin
                    m_windup = 0;
                    m_strike = 1;
                end
            end
        end else if (tick_now) begin
            m_moves++;
            if (m_moves >= every) begin
                m_moves = 0; m_wt = 0; m_windup = 1;
            end else begin
                m_x = ((m_x - 1 + (g ? 1 : NUM_POS - 1)) % NUM_POS) + 1;
            end
        end
    endtask

    task automatic check_all(input string when);
        check({when, ".x_pos"},      int'(x_pos),      m_dead ? 0 : m_x);
        check({when, ".health"},     int'(health),     m_h);
        check({when, ".aggressive"}, int'(aggressive), int'(m_aggr));
        check({when, ".windup"},     int'(windup),     int'(m_windup));
        check({when, ".attack"},     int'(attack),     int'(m_strike));
        check({when, ".dead"},       int'(dead),       int'(m_dead));
    endtask

    function automatic bit pick_hit(input int policy);
        if (m_dead) return bit'($urandom_range(0, 1));
        case (policy)
            1: return $urandom_range(0, 9) == 0;
            2: return m_windup && model_tick_now() && (m_wt == WINDUP_TICKS - 1);
            3: return m_strike;
            4: return m_windup;
            5: return (m_h > 1) ? (!m_windup && !m_strike && $urandom_range(0, 3) == 0)
                                : m_windup;
            default: return 1'b0;
        endcase
    endfunction

    // go_mode: 0 always left, 1 always right, 2 random.
    task automatic run_episode(input int policy, input int cycles, input int go_mode);
        bit g, h;
        @(negedge clock);
        reset = 1'b1;
        hit   = 1'b0;
        #1;
        model_reset();
        check_all("reset_async");
        @(posedge clock);
        #1;
        check_all("reset_held");
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            g = (go_mode == 2) ? bit'($urandom_range(0, 1)) : bit'(go_mode);
            h = pick_hit(policy);
            go  = g;
            hit = h;
            model_step(g, h);
            @(posedge clock);
            #1;
            check_all($sformatf("p%0d", policy));
            @(negedge clock);
        end
        hit = 1'b0;
    endtask

    initial begin
        model_reset();
        run_episode(0, 60, 1);
        run_episode(0, 60, 0);
        for (int rep = 0; rep < 2; rep++) begin
            for (int p = 1; p <= 5; p++)
                run_episode(p, 260, 2);
        end
        run_episode(0, 20, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
